// File: rtl/iq_port_pkg.sv
// Shared types and frame-geometry helpers for the I/Q port serialiser/deserialiser.
package iq_port_pkg;

    typedef enum logic {TX_IDLE, TX_RUN} tx_state_t;
    typedef enum logic {RX_HUNT, RX_LOCK} rx_state_t;

    function automatic int beats(input int sample_w, input int lane_w);
        return sample_w / lane_w;
    endfunction

    function automatic int wpf(input int sample_w, input int lane_w, input int num_ch);
        return 2 * num_ch * beats(sample_w, lane_w);
    endfunction

endpackage

// File: rtl/iq_rx_deframer.sv
// Receive side: hunts for the frame marker, checks alignment, assembles a frame
// and hands it to a single-entry output register with overflow/frame-error flags.
module iq_rx_deframer
    import iq_port_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int LANE_W   = 12,
    parameter int NUM_CH   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame,
    input  logic [LANE_W-1:0]            data,
    input  logic                         out_ready,
    input  logic                         clr_status,
    output logic                         out_valid,
    output logic [2*NUM_CH*SAMPLE_W-1:0] out_data,
    output logic                         rx_overflow,
    output logic                         rx_frame_err
);

    localparam int BEATS = beats(SAMPLE_W, LANE_W);
    localparam int WPF   = wpf(SAMPLE_W, LANE_W, NUM_CH);
    localparam int CW    = (WPF > 1) ? $clog2(WPF) : 1;
    localparam int DW    = 2 * NUM_CH * SAMPLE_W;
    localparam logic [CW-1:0] LAST = CW'(WPF - 1);
    localparam logic [CW-1:0] HALF = CW'(WPF / 2);

    rx_state_t         rx_state, rx_next;
    logic              frame_q, frame_prev, rise, exp_frame;
    logic [LANE_W-1:0] data_q;
    logic [CW-1:0]     cnt, cnt_next, wr_idx;
    logic              wr_en, done_set, err_set, done;
    logic [LANE_W-1:0] asm_words [WPF];
    logic [DW-1:0]     asm_packed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q    <= 1'b0;
            frame_prev <= 1'b0;
            data_q     <= '0;
        end else begin
            frame_q    <= frame;
            frame_prev <= frame_q;
            data_q     <= data;
        end
    end

    assign rise      = frame_q && !frame_prev;
    assign exp_frame = (cnt < HALF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= RX_HUNT;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_HUNT: if (rise) rx_next = RX_LOCK;
            RX_LOCK: if (frame_q != exp_frame && !rise) rx_next = RX_HUNT;
            default: rx_next = RX_HUNT;
        endcase
    end

    // A misaligned word that is itself a rising edge restarts the frame at index 0.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = '0;
        cnt_next = cnt;
        done_set = 1'b0;
        err_set  = 1'b0;
        case (rx_state)
            RX_HUNT: begin
                if (rise) begin
                    wr_en    = 1'b1;
                    cnt_next = CW'(1);
                end
            end
            RX_LOCK: begin
                if (frame_q == exp_frame) begin
                    wr_en  = 1'b1;
                    wr_idx = cnt;
                    if (cnt == LAST) begin
                        cnt_next = '0;
                        done_set = 1'b1;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end else begin
                    err_set = 1'b1;
                    if (rise) begin
                        wr_en    = 1'b1;
                        cnt_next = CW'(1);
                    end else begin
                        cnt_next = '0;
                    end
                end
            end
            default: cnt_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
            for (int i = 0; i < WPF; i++) asm_words[i] <= '0;
        end else begin
            cnt  <= cnt_next;
            done <= done_set;
            if (wr_en) asm_words[wr_idx] <= data_q;
        end
    end

    for (genvar k = 0; k < WPF; k++) begin : g_unpack
        localparam int SMP  = k / BEATS;
        localparam int BASE = (2 * (SMP / 2) + ((SMP % 2 == 0) ? 1 : 0)) * SAMPLE_W;
        localparam int B    = k % BEATS;
        assign asm_packed[BASE + (BEATS - 1 - B) * LANE_W +: LANE_W] = asm_words[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (done && !(out_valid && !out_ready)) begin
            out_valid <= 1'b1;
            out_data  <= asm_packed;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overflow  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else if (clr_status) begin
            rx_overflow  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (done && out_valid && !out_ready) rx_overflow <= 1'b1;
            if (err_set) rx_frame_err <= 1'b1;
        end
    end

endmodule

// File: rtl/iq_port_serdes.sv
// Framed I/Q port bridge: TX serialiser FSM, underrun flag and internal loopback;
// the receive path is delegated to iq_rx_deframer.
module iq_port_serdes
    import iq_port_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int LANE_W   = 12,
    parameter int NUM_CH   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2*NUM_CH*SAMPLE_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*NUM_CH*SAMPLE_W-1:0] out_data,
    output logic                         tx_frame,
    output logic [LANE_W-1:0]            tx_data,
    input  logic                         rx_frame,
    input  logic [LANE_W-1:0]            rx_data,
    input  logic                         loopback,
    input  logic                         clr_status,
    output logic                         tx_underrun,
    output logic                         rx_overflow,
    output logic                         rx_frame_err
);

    localparam int BEATS = beats(SAMPLE_W, LANE_W);
    localparam int WPF   = wpf(SAMPLE_W, LANE_W, NUM_CH);
    localparam int CW    = (WPF > 1) ? $clog2(WPF) : 1;
    localparam int DW    = 2 * NUM_CH * SAMPLE_W;
    localparam logic [CW-1:0] LAST = CW'(WPF - 1);
    localparam logic [CW-1:0] HALF = CW'(WPF / 2);

    if (SAMPLE_W % LANE_W != 0) begin : g_bad_lane
        $fatal(1, "iq_port_serdes: LANE_W must divide SAMPLE_W");
    end
    if (NUM_CH < 1 || NUM_CH > 2) begin : g_bad_ch
        $fatal(1, "iq_port_serdes: NUM_CH must be 1 or 2");
    end

    tx_state_t         tx_state, tx_next;
    logic [CW-1:0]     tx_cnt;
    logic [DW-1:0]     tx_buf;
    logic [LANE_W-1:0] tx_words [WPF];
    logic              accept;
    logic              rx_frame_sel;
    logic [LANE_W-1:0] rx_data_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (accept) tx_next = TX_RUN;
            TX_RUN:  if (tx_cnt == LAST) tx_next = accept ? TX_RUN : TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    // Ready is held low while reset is asserted so nothing is accepted into a cleared FSM.
    always_comb begin
        in_ready = !rst && (tx_state == TX_IDLE || tx_cnt == LAST);
        accept   = in_valid && in_ready;
    end

    for (genvar k = 0; k < WPF; k++) begin : g_pack
        localparam int SMP  = k / BEATS;
        localparam int BASE = (2 * (SMP / 2) + ((SMP % 2 == 0) ? 1 : 0)) * SAMPLE_W;
        localparam int B    = k % BEATS;
        assign tx_words[k] = tx_buf[BASE + (BEATS - 1 - B) * LANE_W +: LANE_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt   <= '0;
            tx_buf   <= '0;
            tx_frame <= 1'b0;
            tx_data  <= '0;
        end else begin
            if (accept) begin
                tx_cnt <= '0;
                tx_buf <= in_data;
            end else if (tx_state == TX_RUN) begin
                tx_cnt <= (tx_cnt == LAST) ? '0 : tx_cnt + CW'(1);
            end
            tx_frame <= (tx_state == TX_RUN) && (tx_cnt < HALF);
            tx_data  <= (tx_state == TX_RUN) ? tx_words[tx_cnt] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          tx_underrun <= 1'b0;
        else if (clr_status)                              tx_underrun <= 1'b0;
        else if (tx_state == TX_RUN && tx_next == TX_IDLE) tx_underrun <= 1'b1;
    end

    assign rx_frame_sel = loopback ? tx_frame : rx_frame;
    assign rx_data_sel  = loopback ? tx_data  : rx_data;

    iq_rx_deframer #(
        .SAMPLE_W (SAMPLE_W),
        .LANE_W   (LANE_W),
        .NUM_CH   (NUM_CH)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .frame        (rx_frame_sel),
        .data         (rx_data_sel),
        .out_ready    (out_ready),
        .clr_status   (clr_status),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .rx_overflow  (rx_overflow),
        .rx_frame_err (rx_frame_err)
    );

endmodule

// File: tb/tb_iq_port_serdes.sv
// Scoreboard bench for iq_port_serdes: a default-parameter instance for basic framing
// and a 6-bit-lane, two-channel instance for loopback, alignment, errors and backpressure.
module tb_iq_port_serdes;

    typedef logic [5:0] word_t;

    localparam logic [47:0] FRAME_A = 48'h6E2F07A5C3D1;
    localparam logic [47:0] FRAME_B = 48'h789ABC123456;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vectors = 0;
    int n_miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        d_in_valid, d_in_ready, d_out_valid, d_tx_frame, d_clr;
    logic [23:0] d_in_data, d_out_data;
    logic [11:0] d_tx_data;
    logic        d_tx_underrun, d_rx_overflow, d_rx_frame_err;

    logic        in_valid, in_ready, out_valid, out_ready, tx_frame, rx_frame;
    logic        loopback, clr_status, tx_underrun, rx_overflow, rx_frame_err;
    logic [47:0] in_data, out_data;
    word_t       tx_data, rx_data;

    iq_port_serdes u_def (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(1'b1), .out_data(d_out_data),
        .tx_frame(d_tx_frame), .tx_data(d_tx_data),
        .rx_frame(1'b0), .rx_data(12'h000),
        .loopback(1'b0), .clr_status(d_clr),
        .tx_underrun(d_tx_underrun), .rx_overflow(d_rx_overflow), .rx_frame_err(d_rx_frame_err)
    );

    iq_port_serdes #(.SAMPLE_W(12), .LANE_W(6), .NUM_CH(2)) u_nar (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .tx_frame(tx_frame), .tx_data(tx_data),
        .rx_frame(rx_frame), .rx_data(rx_data),
        .loopback(loopback), .clr_status(clr_status),
        .tx_underrun(tx_underrun), .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err)
    );

    word_t       words_a [8];
    word_t       words_b [8];
    logic [6:0]  tx_q [$];
    logic [47:0] rx_q [$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic f, input word_t w);
        rx_frame = f;
        rx_data  = w;
        tick();
    endtask

    task automatic sendRxFrame(input int which, input int flip_idx, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            logic  f;
            word_t w;
            f = (k < 4);
            if (k == flip_idx) f = ~f;
            w = (which == 0) ? words_a[k] : words_b[k];
            applyStimulus(f, w);
        end
    endtask

    task automatic pushTx(input int which, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            logic f;
            f = (k < 4);
            tx_q.push_back({f, (which == 0) ? words_a[k] : words_b[k]});
        end
    endtask

    task automatic rxIdleCheck(input string name, input logic exp_err);
        rx_frame = 1'b0;
        rx_data  = '0;
        tick();
        @(negedge clk);
        checkOutput(name, rx_frame_err, exp_err);
    endtask

    task automatic pulseClear;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        @(negedge clk);
    endtask

    int          tx_mcnt = 0;
    logic        tx_prev = 1'b0;
    logic [6:0]  tx_e;
    logic [47:0] rx_e;

    // TX monitor: a rising frame marker starts a frame, then every word is checked.
    always @(negedge clk) begin
        if (rst) begin
            tx_mcnt = 0;
            tx_prev = 1'b0;
        end else begin
            if (tx_mcnt != 0 || (tx_frame && !tx_prev)) begin
                if (tx_q.size() == 0) begin
                    checkOutput("tx_unexpected", 64'd1, 64'd0);
                end else begin
                    tx_e = tx_q.pop_front();
                    checkOutput("tx_word", {tx_frame, tx_data}, tx_e);
                end
                tx_mcnt = (tx_mcnt == 7) ? 0 : tx_mcnt + 1;
            end
            tx_prev = tx_frame;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (rx_q.size() == 0) begin
                checkOutput("rx_unexpected", 64'd1, 64'd0);
            end else begin
                rx_e = rx_q.pop_front();
                checkOutput("rx_out_data", out_data, rx_e);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int acc;
        words_a = '{6'h29, 6'h1C, 6'h0F, 6'h11, 6'h1B, 6'h22, 6'h3C, 6'h07};
        words_b = '{6'h04, 6'h23, 6'h11, 6'h16, 6'h1E, 6'h09, 6'h2A, 6'h3C};
        d_in_valid = 1'b0; d_in_data = '0; d_clr = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        rx_frame = 1'b0; rx_data = '0; loopback = 1'b0; clr_status = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", {in_ready, d_in_ready}, 2'b00);
        checkOutput("rst_out_valid", {out_valid, d_out_valid}, 2'b00);
        checkOutput("rst_tx", {tx_frame, tx_data}, 7'h00);
        checkOutput("rst_flags", {tx_underrun, rx_overflow, rx_frame_err}, 3'b000);
        checkOutput("rst_out_data", out_data, 48'h0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("rel_in_ready", {in_ready, d_in_ready}, 2'b11);

        // Default geometry: one channel, full-width lane, two words per frame.
        tick();
        d_in_valid = 1'b1;
        d_in_data  = 24'hABC123;
        @(negedge clk);
        checkOutput("def_ready", d_in_ready, 1'b1);
        tick();
        d_in_valid = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("def_word0", {d_tx_frame, d_tx_data}, {1'b1, 12'hABC});
        tick();
        @(negedge clk);
        checkOutput("def_word1", {d_tx_frame, d_tx_data}, {1'b0, 12'h123});
        checkOutput("def_underrun", d_tx_underrun, 1'b1);
        tick();
        @(negedge clk);
        checkOutput("def_idle", {d_tx_frame, d_tx_data}, 13'h0);
        tick();
        d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
        @(negedge clk);
        checkOutput("def_clr", d_tx_underrun, 1'b0);

        // Loopback with two back-to-back frames.
        tick();
        loopback = 1'b1;
        pushTx(0, 8);
        pushTx(1, 8);
        rx_q.push_back(FRAME_A);
        rx_q.push_back(FRAME_B);
        in_valid = 1'b1;
        in_data  = FRAME_A;
        @(negedge clk);
        checkOutput("lb_ready_idle", in_ready, 1'b1);
        tick();
        acc = cyc;
        in_data = FRAME_B;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (in_ready) break;
            tick();
            k++;
        end
        tick();
        in_valid = 1'b0;
        checkOutput("b2b_interval", k + 1, 8);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 40);
        checkOutput("lb_latency", cyc - acc, 11);
        repeat (12) tick();
        @(negedge clk);
        checkOutput("lb_underrun", tx_underrun, 1'b1);
        checkOutput("lb_tx_idle", {tx_frame, tx_data}, 7'h00);
        tick();
        loopback = 1'b0;
        pulseClear();
        checkOutput("lb_clr", {tx_underrun, rx_frame_err}, 2'b00);

        // Alignment: stray words first, then two contiguous frames on the pins.
        tick();
        rx_q.push_back(FRAME_B);
        rx_q.push_back(FRAME_A);
        applyStimulus(1'b0, 6'h2A);
        applyStimulus(1'b0, 6'h15);
        sendRxFrame(1, -1, 8);
        sendRxFrame(0, -1, 8);
        rxIdleCheck("align_no_err", 1'b0);
        repeat (4) tick();
        pulseClear();

        // Truncated frame interrupted by a fresh rising edge.
        tick();
        rx_q.push_back(FRAME_B);
        sendRxFrame(0, -1, 5);
        sendRxFrame(1, -1, 8);
        rxIdleCheck("err_restart", 1'b1);
        repeat (4) tick();
        pulseClear();
        checkOutput("err_clr", rx_frame_err, 1'b0);

        // Frame bit flipped at index 1: that frame is lost, the next one arrives.
        tick();
        rx_q.push_back(FRAME_B);
        sendRxFrame(0, 1, 8);
        sendRxFrame(1, -1, 8);
        rxIdleCheck("err_flip", 1'b1);
        repeat (4) tick();
        pulseClear();

        // Backpressure across two completions.
        tick();
        out_ready = 1'b0;
        rx_q.push_back(FRAME_A);
        sendRxFrame(0, -1, 8);
        sendRxFrame(1, -1, 8);
        rx_frame = 1'b0;
        rx_data  = '0;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("ovf_flag", rx_overflow, 1'b1);
        checkOutput("ovf_hold_valid", out_valid, 1'b1);
        checkOutput("ovf_hold_data", out_data, FRAME_A);
        tick();
        out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("ovf_drained", out_valid, 1'b0);
        pulseClear();
        checkOutput("ovf_clr", {rx_overflow, rx_frame_err}, 2'b00);

        // Reset while word 1 of a TX frame is on the port.
        tick();
        pushTx(0, 2);
        in_valid = 1'b1;
        in_data  = FRAME_A;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_tx", {tx_frame, tx_data}, 7'h00);
        checkOutput("rst_mid_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_ready_back", in_ready, 1'b1);
        repeat (12) tick();
        @(negedge clk);
        checkOutput("rst_mid_flags", {tx_underrun, rx_overflow, rx_frame_err}, 3'b000);
        checkOutput("rst_mid_idle", {tx_frame, tx_data, out_valid}, 8'h00);

        checkOutput("tx_q_left", tx_q.size(), 0);
        checkOutput("rx_q_left", rx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
